decode_issue: RTL and testbench

Decode/issue stage sitting directly upstream of the register file and downstream of fetch. It decodes a 16-bit instruction and drives the RF read addresses from it. It captures the RF read data into an issue register and hands the instruction to execute over a valid/ready handshake. A 16-bit pending-write scoreboard blocks issue on RAW and WAW hazards until the producing write reaches the RF write port.

---
 rtl/decode_issue_pkg.sv | 55 +++++
 rtl/decode_issue_scoreboard.sv | 37 +++
 rtl/decode_issue.sv | 111 +++++++++++
 tb/tb_decode_issue.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_pkg.sv
// Shared widths, instruction field positions, opcode classes and the issue payload.
package decode_issue_pkg;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned ADDR_W  = 4;
   localparam int unsigned NREG    = 16;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned INSTR_W = 16;

   // Field slice positions inside the 16-bit instruction word
   localparam int unsigned OP_LSB = 12;
   localparam int unsigned RD_LSB = 8;
   localparam int unsigned RS_LSB = 4;
   localparam int unsigned RT_LSB = 0;

   // Opcode map
   localparam logic [OP_W-1:0] OP_ALU_MAX = 4'h7;
   localparam logic [OP_W-1:0] OP_LW      = 4'h8;
   localparam logic [OP_W-1:0] OP_SW      = 4'h9;
   localparam logic [OP_W-1:0] OP_BR_MIN  = 4'hA;
   localparam logic [OP_W-1:0] OP_BR_MAX  = 4'hE;
   localparam logic [OP_W-1:0] OP_NOP     = 4'hF;

   // Register usage of one opcode
   typedef struct packed {
      logic uses_rs;
      logic uses_rt;
      logic writes_rd;
   } op_class_t;

   // Contents of the issue register handed to execute
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } issue_t;

   // Map an opcode to the registers it reads and whether it writes rd
   function automatic op_class_t decode_class(input logic [OP_W-1:0] op);
      op_class_t c;
      c = '0;
      if (op <= OP_ALU_MAX) begin
         c = '{uses_rs: 1'b1, uses_rt: 1'b1, writes_rd: 1'b1};
      end else if (op == OP_LW) begin
         c = '{uses_rs: 1'b1, uses_rt: 1'b0, writes_rd: 1'b1};
      end else if (op == OP_SW || (op >= OP_BR_MIN && op <= OP_BR_MAX)) begin
         c = '{uses_rs: 1'b1, uses_rt: 1'b1, writes_rd: 1'b0};
      end else begin
         c = '0;
      end
      return c;
   endfunction

endpackage

// File: rtl/decode_issue_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue of a writer, cleared at RF writeback.
module issue_scoreboard
   import decode_issue_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_set_en,
   input  logic [ADDR_W-1:0] i_set_addr,
   input  logic              i_clr_en,
   input  logic [ADDR_W-1:0] i_clr_addr,
   output logic [NREG-1:0]   o_pend_eff
);

   logic [NREG-1:0] r_pend;
   logic [NREG-1:0] w_set_mask;
   logic [NREG-1:0] w_clr_mask;

   // One-hot set/clear masks; a same-cycle writeback already hides the pending bit
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (i_set_en) w_set_mask = NREG'(1) << i_set_addr;
      if (i_clr_en) w_clr_mask = NREG'(1) << i_clr_addr;
   end

   assign o_pend_eff = r_pend & ~w_clr_mask;

   // Clear first, then set, so a set on the cleared address wins
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend <= '0;
      end else begin
         r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
      end
   end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes fetch instructions, interlocks on pending writes, captures RF operands.
module decode_issue
   import decode_issue_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               in_ready,
   output logic [ADDR_W-1:0]  p0_addr,
   output logic [ADDR_W-1:0]  p1_addr,
   input  logic [DATA_W-1:0]  p0,
   input  logic [DATA_W-1:0]  p1,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OP_W-1:0]    out_op,
   output logic [ADDR_W-1:0]  out_rd,
   output logic [DATA_W-1:0]  out_a,
   output logic [DATA_W-1:0]  out_b,
   input  logic               wb_we,
   input  logic [ADDR_W-1:0]  wb_addr,
   input  logic               flush
);

   logic              r_valid;
   issue_t            r_issue;

   logic [OP_W-1:0]   w_op;
   logic [ADDR_W-1:0] w_rd;
   logic [ADDR_W-1:0] w_rs;
   logic [ADDR_W-1:0] w_rt;
   op_class_t         w_cls;
   op_class_t         w_iss_cls;
   logic [NREG-1:0]   w_pend_eff;
   logic              w_sb_haz;
   logic              w_iss_haz;
   logic              w_ready;
   logic              w_accept;
   logic              w_sb_set;
   issue_t            w_capture;

   // Field extraction; RF read addresses follow the instruction regardless of in_valid
   assign w_op    = in_instr[OP_LSB +: OP_W];
   assign w_rd    = in_instr[RD_LSB +: ADDR_W];
   assign w_rs    = in_instr[RS_LSB +: ADDR_W];
   assign w_rt    = in_instr[RT_LSB +: ADDR_W];
   assign p0_addr = w_rs;
   assign p1_addr = w_rt;

   assign w_cls     = decode_class(w_op);
   assign w_iss_cls = decode_class(r_issue.op);

   // Hazards against outstanding writes and against a writer still sitting in the issue register
   always_comb begin
      w_sb_haz  = (w_cls.uses_rs   & w_pend_eff[w_rs])
                | (w_cls.uses_rt   & w_pend_eff[w_rt])
                | (w_cls.writes_rd & w_pend_eff[w_rd]);
      w_iss_haz = r_valid & w_iss_cls.writes_rd &
                  ((w_cls.uses_rs   & (r_issue.rd == w_rs))
                 | (w_cls.uses_rt   & (r_issue.rd == w_rt))
                 | (w_cls.writes_rd & (r_issue.rd == w_rd)));
   end

   assign w_ready  = ~(w_sb_haz | w_iss_haz) & (~r_valid | out_ready) & ~flush;
   assign in_ready = w_ready;
   assign w_accept = in_valid & w_ready;

   // A flushed instruction never reaches execute, so it must not mark its destination
   assign w_sb_set = r_valid & out_ready & ~flush & w_iss_cls.writes_rd;

   // Operand capture; unused operands are zeroed
   always_comb begin
      w_capture    = '0;
      w_capture.op = w_op;
      w_capture.rd = w_rd;
      w_capture.a  = w_cls.uses_rs ? p0 : '0;
      w_capture.b  = w_cls.uses_rt ? p1 : '0;
   end

   // Issue register: flush kills, accept loads, handoff without refill empties, otherwise hold
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_issue <= '{op: OP_NOP, rd: '0, a: '0, b: '0};
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_issue <= w_capture;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   issue_scoreboard u_sb (
      .clk        (clk),
      .rst        (rst),
      .i_set_en   (w_sb_set),
      .i_set_addr (r_issue.rd),
      .i_clr_en   (wb_we),
      .i_clr_addr (wb_addr),
      .o_pend_eff (w_pend_eff)
   );

   assign out_valid = r_valid;
   assign out_op    = r_issue.op;
   assign out_rd    = r_issue.rd;
   assign out_a     = r_issue.a;
   assign out_b     = r_issue.b;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios, then random traffic checked by a scoreboard queue.
module tb_decode_issue;

   localparam int NUM_RAND = 300;

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [15:0] a;
      logic [15:0] b;
      bit          wr;
      logic [15:0] val;
   } exp_t;

   typedef struct {
      logic [3:0]  addr;
      logic [15:0] data;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_instr = 16'hF000;
   logic        in_ready;
   logic [3:0]  p0_addr, p1_addr;
   logic [15:0] p0, p1;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_op, out_rd;
   logic [15:0] out_a, out_b;
   logic        wb_we;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic        flush = 1'b0;

   // Directed-mode and random-mode drive of execute/writeback side
   bit          rand_en = 1'b0;
   logic        d_or = 1'b0, d_we = 1'b0;
   logic [3:0]  d_wa = '0;
   logic [15:0] d_wd = '0;
   logic        r_or = 1'b0, r_we = 1'b0;
   logic [3:0]  r_wa = '0;
   logic [15:0] r_wd = '0;

   assign out_ready = rand_en ? r_or : d_or;
   assign wb_we     = rand_en ? r_we : d_we;
   assign wb_addr   = rand_en ? r_wa : d_wa;
   assign wb_data   = rand_en ? r_wd : d_wd;

   int n_chk = 0;
   int n_fail = 0;
   int n_issued = 0;

   logic [15:0] rf [16];
   logic [15:0] mdl [16];
   logic [15:0] arch [16];
   exp_t        expq[$];
   wb_t         wbq[$];

   always #5 clk = ~clk;

   decode_issue dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
      .p0_addr(p0_addr), .p1_addr(p1_addr), .p0(p0), .p1(p1),
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd),
      .out_a(out_a), .out_b(out_b), .wb_we(wb_we), .wb_addr(wb_addr), .flush(flush)
   );

   // Register file model: write in the high phase is visible to the same-cycle read
   assign p0 = (wb_we && wb_addr == p0_addr) ? wb_data : rf[p0_addr];
   assign p1 = (wb_we && wb_addr == p1_addr) ? wb_data : rf[p1_addr];
   always @(posedge clk) if (wb_we) rf[wb_addr] <= wb_data;

   function automatic bit m_wr(input logic [3:0] op); return op <= 4'd8; endfunction
   function automatic bit m_rs(input logic [3:0] op); return op != 4'd15; endfunction
   function automatic bit m_rt(input logic [3:0] op); return op != 4'd8 && op != 4'd15; endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic summary();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic at_neg();
      @(negedge clk); #2;
   endtask

   task automatic wb_write(input logic [3:0] a, input logic [15:0] d);
      d_we = 1'b1; d_wa = a; d_wd = d; mdl[a] = d;
      step();
      d_we = 1'b0;
   endtask

   // Random execute side and writeback engine, plus the output monitor
   always @(negedge clk) begin
      if (rand_en) begin
         wb_t  w;
         exp_t e;
         if (wbq.size() > 0 && ($urandom % 2) == 0) begin
            w = wbq.pop_front();
            r_we = 1'b1; r_wa = w.addr; r_wd = w.data;
         end else begin
            r_we = 1'b0;
         end
         r_or = ($urandom % 4) != 0;
         if (out_valid && r_or) begin
            if (expq.size() == 0) begin
               chk("unexpected_issue", 32'(out_op), 32'hFFFF_FFFF);
            end else begin
               e = expq.pop_front();
               n_issued++;
               chk("issue_op", 32'(out_op), 32'(e.op));
               chk("issue_rd", 32'(out_rd), 32'(e.rd));
               chk("issue_a",  32'(out_a),  32'(e.a));
               chk("issue_b",  32'(out_b),  32'(e.b));
               if (e.wr) wbq.push_back('{addr: e.rd, data: e.val});
            end
         end
      end else begin
         r_we = 1'b0;
         r_or = 1'b0;
      end
   end

   initial begin
      logic [15:0] ins;
      exp_t        e;
      bit          acc;
      int          cnt;

      // Reset values
      #12;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_op",    32'(out_op), 32'hF);
      chk("rst_rd",    32'(out_rd), 0);
      chk("rst_a",     32'(out_a), 0);
      chk("rst_b",     32'(out_b), 0);
      chk("rst_ready", 32'(in_ready), 1);
      rst = 1'b1;
      step();
      for (int r = 0; r < 16; r++)
         wb_write(4'(r), (r == 2) ? 16'd5 : (r == 3) ? 16'd7 : 16'(16'h1000 + r * 16'h0111));

      // ALU R1 = R2 + R3
      in_instr = 16'h0123; in_valid = 1'b1; d_or = 1'b1;
      at_neg();
      chk("alu_ready", 32'(in_ready), 1);
      chk("alu_p0addr", 32'(p0_addr), 2);
      chk("alu_p1addr", 32'(p1_addr), 3);
      step();
      chk("alu_valid", 32'(out_valid), 1);
      chk("alu_op", 32'(out_op), 0);
      chk("alu_rd", 32'(out_rd), 1);
      chk("alu_a", 32'(out_a), 5);
      chk("alu_b", 32'(out_b), 7);

      // RAW on R1: stall until the R1 writeback, accepted in that cycle
      in_instr = 16'h0512;
      for (int i = 0; i < 3; i++) begin
         at_neg();
         chk("raw_stall", 32'(in_ready), 0);
         step();
      end
      d_we = 1'b1; d_wa = 4'd1; d_wd = 16'h1234; mdl[1] = 16'h1234;
      at_neg();
      chk("raw_wb_ready", 32'(in_ready), 1);
      step();
      chk("raw_a", 32'(out_a), 32'h1234);
      chk("raw_b", 32'(out_b), 5);
      chk("raw_rd", 32'(out_rd), 5);
      d_we = 1'b0; in_valid = 1'b0;
      step();
      wb_write(4'd5, 16'h0055);

      // Back-pressure with a second instruction waiting
      d_or = 1'b0; in_instr = 16'h0723; in_valid = 1'b1;
      step();
      chk("bp_first_rd", 32'(out_rd), 7);
      in_instr = 16'h0823;
      for (int i = 0; i < 3; i++) begin
         at_neg();
         chk("bp_ready", 32'(in_ready), 0);
         step();
         chk("bp_hold_valid", 32'(out_valid), 1);
         chk("bp_hold_rd", 32'(out_rd), 7);
         chk("bp_hold_ab", {out_a, out_b}, 32'h0005_0007);
      end
      d_or = 1'b1;
      at_neg();
      chk("bp_release_ready", 32'(in_ready), 1);
      step();
      chk("bp_next_rd", 32'(out_rd), 8);
      in_valid = 1'b0;
      step();
      chk("bp_drained", 32'(out_valid), 0);
      wb_write(4'd7, 16'h0077);
      wb_write(4'd8, 16'h0088);

      // WAW: LW R4 outstanding, ALU writing R4 must wait for its writeback
      in_instr = 16'h8400; in_valid = 1'b1;
      step();
      chk("lw_a", 32'(out_a), 32'(mdl[0]));
      chk("lw_b_zero", 32'(out_b), 0);
      in_instr = 16'h0423;
      for (int i = 0; i < 3; i++) begin
         at_neg();
         chk("waw_stall", 32'(in_ready), 0);
         step();
      end
      d_we = 1'b1; d_wa = 4'd4; d_wd = 16'h4444; mdl[4] = 16'h4444;
      at_neg();
      chk("waw_wb_ready", 32'(in_ready), 1);
      step();
      chk("waw_rd", 32'(out_rd), 4);
      d_we = 1'b0; in_valid = 1'b0;
      step();
      wb_write(4'd4, 16'h4445);

      // Flush a held writer of R6; its destination must not become pending
      d_or = 1'b0; in_instr = 16'h0623; in_valid = 1'b1;
      step();
      flush = 1'b1; d_or = 1'b1; in_instr = 16'hF000;
      at_neg();
      chk("flush_blocks", 32'(in_ready), 0);
      step();
      chk("flush_valid", 32'(out_valid), 0);
      flush = 1'b0; in_instr = 16'h9060;
      at_neg();
      chk("flush_no_pend", 32'(in_ready), 1);
      step();
      chk("sw_op", 32'(out_op), 9);
      chk("sw_a", 32'(out_a), 32'(mdl[6]));
      chk("sw_b", 32'(out_b), 32'(mdl[0]));
      in_valid = 1'b0;
      step();

      // Back-to-back writers R4..R7, then async reset with a held NOP
      for (int i = 4; i < 8; i++) begin
         in_instr = {4'h0, 4'(i), 8'h00}; in_valid = 1'b1;
         at_neg();
         chk("b2b_ready", 32'(in_ready), 1);
         step();
      end
      in_instr = 16'hF900;
      at_neg();
      chk("b2b_nop_ready", 32'(in_ready), 1);
      step();
      d_or = 1'b0; in_valid = 1'b0; in_instr = 16'h0044;
      step();
      chk("pre_rst_valid", 32'(out_valid), 1);
      chk("pre_rst_rd", 32'(out_rd), 9);
      d_or = 1'b1;
      #1;
      chk("pre_rst_pend", 32'(in_ready), 0);
      #1 rst = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_rd", 32'(out_rd), 0);
      chk("arst_op", 32'(out_op), 32'hF);
      chk("arst_pend", 32'(in_ready), 1);
      #3 rst = 1'b1;
      step();

      // Random traffic against an in-order architectural model
      for (int r = 0; r < 16; r++) arch[r] = mdl[r];
      rand_en = 1'b1;
      for (int k = 0; k < NUM_RAND; k++) begin
         if (($urandom % 4) == 0) begin
            in_valid = 1'b0;
            step();
         end
         ins = 16'($urandom);
         e.op  = ins[15:12];
         e.rd  = ins[11:8];
         e.a   = m_rs(e.op) ? arch[ins[7:4]] : 16'h0;
         e.b   = m_rt(e.op) ? arch[ins[3:0]] : 16'h0;
         e.wr  = m_wr(e.op);
         e.val = 16'($urandom);
         if (e.wr) arch[e.rd] = e.val;
         expq.push_back(e);
         in_valid = 1'b1; in_instr = ins;
         acc = 1'b0; cnt = 0;
         at_neg();
         chk("rand_p0addr", 32'(p0_addr), 32'(ins[7:4]));
         chk("rand_p1addr", 32'(p1_addr), 32'(ins[3:0]));
         while (!acc) begin
            if (cnt > 0) at_neg();
            acc = in_ready;
            step();
            cnt++;
            if (cnt > 300) begin
               chk("accept_timeout", 32'(cnt), 0);
               summary();
            end
         end
      end
      in_valid = 1'b0;
      cnt = 0;
      while ((expq.size() != 0 || wbq.size() != 0) && cnt < 3000) begin
         step();
         cnt++;
      end
      chk("drain_timeout", 32'(cnt < 3000), 1);
      step();
      step();
      rand_en = 1'b0;
      chk("issued_count", 32'(n_issued), 32'(NUM_RAND));
      summary();
   end

endmodule
